// File: rtl/ir_nec_decoder_pkg.sv
// Shared constants and state type for the NEC infrared decoder.
// All width limits are in timing ticks and are inclusive on both ends.
package ir_pkg;

  localparam int WIDTH_W = 11;

  localparam logic [WIDTH_W-1:0] LEAD_MARK_MIN     = 11'd800;
  localparam logic [WIDTH_W-1:0] LEAD_MARK_MAX     = 11'd1000;
  localparam logic [WIDTH_W-1:0] LEAD_SPC_DATA_MIN = 11'd400;
  localparam logic [WIDTH_W-1:0] LEAD_SPC_DATA_MAX = 11'd500;
  localparam logic [WIDTH_W-1:0] LEAD_SPC_REP_MIN  = 11'd200;
  localparam logic [WIDTH_W-1:0] LEAD_SPC_REP_MAX  = 11'd250;
  localparam logic [WIDTH_W-1:0] BIT_MARK_MIN      = 11'd40;
  localparam logic [WIDTH_W-1:0] BIT_MARK_MAX      = 11'd70;
  localparam logic [WIDTH_W-1:0] BIT_SPC0_MIN      = 11'd40;
  localparam logic [WIDTH_W-1:0] BIT_SPC0_MAX      = 11'd70;
  localparam logic [WIDTH_W-1:0] BIT_SPC1_MIN      = 11'd140;
  localparam logic [WIDTH_W-1:0] BIT_SPC1_MAX      = 11'd200;
  localparam logic [WIDTH_W-1:0] WIDTH_SAT         = 11'd2047;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_MARK,
    ST_LEAD_SPACE,
    ST_BIT_MARK,
    ST_BIT_SPACE,
    ST_STOP_MARK
  } ir_state_t;

  function automatic logic in_range(input logic [WIDTH_W-1:0] w,
                                    input logic [WIDTH_W-1:0] lo,
                                    input logic [WIDTH_W-1:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_nec_decoder_if.sv
// Pin-side inputs and decoded-result outputs of the NEC decoder.
// master = the decoder itself, slave = pin driver / system controller side.
interface ir_nec_decoder_if;
  logic        ir_in;
  logic        defv;
  logic        frame_valid;
  logic [15:0] addr;
  logic [7:0]  cmd;
  logic        repeat_valid;
  logic        frame_err;
  logic        busy;

  modport master (
    input  ir_in, defv,
    output frame_valid, addr, cmd, repeat_valid, frame_err, busy
  );

  modport slave (
    output ir_in, defv,
    input  frame_valid, addr, cmd, repeat_valid, frame_err, busy
  );
endinterface

// File: rtl/ir_nec_decoder_deglitch.sv
// Two-flop synchroniser followed by a stable-count filter on the raw IR pin.
// toggle pulses for one cycle on the cycle the accepted level has just changed.
module ir_deglitch #(
  parameter int GLITCH_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic rst_val,
  output logic level,
  output logic toggle
);

  localparam int CW = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= rst_val;
      sync2      <= rst_val;
      level      <= rst_val;
      stable_cnt <= '0;
      toggle     <= 1'b0;
    end else begin
      sync1  <= din;
      sync2  <= sync1;
      toggle <= 1'b0;
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(GLITCH_CYC - 1)) begin
        level      <= sync2;
        stable_cnt <= '0;
        toggle     <= 1'b1;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC infrared frame decoder: measures filtered mark/space widths in ticks and
// emits one-cycle strobes for data frames, repeat codes and malformed frames.
//
// state        | meaning
// -------------+--------------------------------------------------
// IDLE         | waiting for a mark rising edge
// LEAD_MARK    | measuring the 9 ms leader mark
// LEAD_SPACE   | measuring leader space (data 4.5 ms / repeat 2.25 ms)
// BIT_MARK     | measuring a 560 us bit mark
// BIT_SPACE    | measuring bit space, its width selects 0 or 1
// STOP_MARK    | measuring the final mark, then frame is judged
module ir_nec_decoder
  import ir_pkg::*;
#(
  parameter int TICK_DIV   = 250,
  parameter int GLITCH_CYC = 8,
  parameter int REP_WIN    = 12000
) (
  input  logic              clk,
  input  logic              rst,
  ir_nec_decoder_if.master  bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic               level;
  logic               toggle;
  logic               mark;
  logic               defv_q;
  logic               defv_chg;
  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic [WIDTH_W-1:0] width;
  logic [13:0]        rep_cnt;
  logic               rep_open;
  logic               rep_load;

  ir_state_t   state, state_nxt;
  logic [31:0] sr, sr_nxt;
  logic [4:0]  bit_idx, idx_nxt;
  logic        rep_flag, rep_nxt;
  logic        fv_d, rv_d, fe_d;

  logic        frame_valid_q;
  logic        repeat_valid_q;
  logic        frame_err_q;
  logic [15:0] addr_q;
  logic [7:0]  cmd_q;

  ir_deglitch #(.GLITCH_CYC(GLITCH_CYC)) u_deglitch (
    .clk     (clk),
    .rst     (rst),
    .din     (bus.ir_in),
    .rst_val (~bus.defv),
    .level   (level),
    .toggle  (toggle)
  );

  // Normalised so mark = 1 regardless of receiver polarity.
  assign mark     = ~(level ^ bus.defv);
  assign defv_chg = (bus.defv != defv_q);
  assign tick     = (tick_cnt == '0);
  assign rep_open = (rep_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      defv_q   <= bus.defv;
      tick_cnt <= TW'(TICK_DIV - 1);
      width    <= '0;
      rep_cnt  <= '0;
    end else begin
      defv_q <= bus.defv;
      if (tick) tick_cnt <= TW'(TICK_DIV - 1);
      else      tick_cnt <= tick_cnt - 1'b1;

      if (toggle)                          width <= '0;
      else if (tick && width != WIDTH_SAT) width <= width + 1'b1;

      if (rep_load)              rep_cnt <= 14'(REP_WIN);
      else if (tick && rep_open) rep_cnt <= rep_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sr       <= '0;
      bit_idx  <= '0;
      rep_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      sr       <= sr_nxt;
      bit_idx  <= idx_nxt;
      rep_flag <= rep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    idx_nxt   = bit_idx;
    rep_nxt   = rep_flag;
    fv_d      = 1'b0;
    rv_d      = 1'b0;
    fe_d      = 1'b0;
    rep_load  = 1'b0;

    // A polarity change mid-frame is a configuration event, not a bad frame.
    if (state != ST_IDLE && defv_chg) begin
      state_nxt = ST_IDLE;
    end else if (state != ST_IDLE && width == WIDTH_SAT) begin
      fe_d      = 1'b1;
      state_nxt = ST_IDLE;
    end else if (toggle) begin
      case (state)
        ST_IDLE: begin
          if (mark) state_nxt = ST_LEAD_MARK;
        end
        ST_LEAD_MARK: begin
          if (in_range(width, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
            state_nxt = ST_LEAD_SPACE;
          end else begin
            fe_d      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_LEAD_SPACE: begin
          if (in_range(width, LEAD_SPC_DATA_MIN, LEAD_SPC_DATA_MAX)) begin
            state_nxt = ST_BIT_MARK;
            idx_nxt   = '0;
            rep_nxt   = 1'b0;
          end else if (in_range(width, LEAD_SPC_REP_MIN, LEAD_SPC_REP_MAX)) begin
            state_nxt = ST_STOP_MARK;
            rep_nxt   = 1'b1;
          end else begin
            fe_d      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BIT_MARK: begin
          if (in_range(width, BIT_MARK_MIN, BIT_MARK_MAX)) begin
            state_nxt = ST_BIT_SPACE;
          end else begin
            fe_d      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BIT_SPACE: begin
          if (in_range(width, BIT_SPC0_MIN, BIT_SPC0_MAX) ||
              in_range(width, BIT_SPC1_MIN, BIT_SPC1_MAX)) begin
            sr_nxt    = {in_range(width, BIT_SPC1_MIN, BIT_SPC1_MAX), sr[31:1]};
            idx_nxt   = bit_idx + 5'd1;
            state_nxt = (bit_idx == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
          end else begin
            fe_d      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_STOP_MARK: begin
          state_nxt = ST_IDLE;
          if (!in_range(width, BIT_MARK_MIN, BIT_MARK_MAX)) begin
            fe_d = 1'b1;
          end else if (rep_flag) begin
            // Stale repeats are dropped without flagging an error.
            if (rep_open) begin
              rv_d     = 1'b1;
              rep_load = 1'b1;
            end
          end else if (sr[23:16] == ~sr[31:24]) begin
            fv_d     = 1'b1;
            rep_load = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid_q  <= 1'b0;
      repeat_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      addr_q         <= '0;
      cmd_q          <= '0;
    end else begin
      frame_valid_q  <= fv_d;
      repeat_valid_q <= rv_d;
      frame_err_q    <= fe_d;
      if (fv_d) begin
        addr_q <= sr[15:0];
        cmd_q  <= sr[23:16];
      end
    end
  end

  assign bus.frame_valid  = frame_valid_q;
  assign bus.repeat_valid = repeat_valid_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.addr         = addr_q;
  assign bus.cmd          = cmd_q;
  assign bus.busy         = (state != ST_IDLE);

endmodule
